// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the TCM command/response bus.
// slave: the arbiter side; master: requesters plus memory environment.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int BW = DATA_WIDTH / 8;

    logic                  p0_req_i;
    logic                  p0_we_i;
    logic [ADDR_WIDTH-1:0] p0_addr_i;
    logic [BW-1:0]         p0_be_i;
    logic [DATA_WIDTH-1:0] p0_wdata_i;
    logic                  p0_gnt_o;
    logic                  p0_rvalid_o;
    logic [DATA_WIDTH-1:0] p0_rdata_o;

    logic                  p1_req_i;
    logic                  p1_we_i;
    logic [ADDR_WIDTH-1:0] p1_addr_i;
    logic [BW-1:0]         p1_be_i;
    logic [DATA_WIDTH-1:0] p1_wdata_i;
    logic                  p1_gnt_o;
    logic                  p1_rvalid_o;
    logic [DATA_WIDTH-1:0] p1_rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [BW-1:0]         mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_be_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_be_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data TCM arbiter: two requesters, round-robin grant, one command per cycle.
// Responses ride a MEM_LATENCY-deep shift register back to their owner.
module dmem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;

    typedef struct packed {
        logic valid;
        logic owner;
        logic we;
    } rsp_t;

    logic                  last_gnt_q, last_gnt_d;
    rsp_t                  pipe_q [MEM_LATENCY];
    rsp_t                  pipe_d [MEM_LATENCY];
    rsp_t                  head;
    logic                  gnt0, gnt1;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [BW-1:0]         cmd_be;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rv0, rv1;

    // last_gnt_q names the port granted most recently; a tie goes to the other.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.p0_req_i && bus.p1_req_i) begin
                gnt0 = last_gnt_q;
                gnt1 = ~last_gnt_q;
            end else begin
                gnt0 = bus.p0_req_i;
                gnt1 = bus.p1_req_i;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) last_gnt_d = 1'b0;
        if (gnt1) last_gnt_d = 1'b1;
    end

    always_comb begin
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_be    = '0;
        cmd_wdata = '0;
        if (gnt0) begin
            cmd_we    = bus.p0_we_i;
            cmd_addr  = bus.p0_addr_i;
            cmd_be    = bus.p0_be_i;
            cmd_wdata = bus.p0_wdata_i;
        end else if (gnt1) begin
            cmd_we    = bus.p1_we_i;
            cmd_addr  = bus.p1_addr_i;
            cmd_be    = bus.p1_be_i;
            cmd_wdata = bus.p1_wdata_i;
        end
    end

    assign bus.p0_gnt_o    = gnt0;
    assign bus.p1_gnt_o    = gnt1;
    assign bus.mem_req_o   = gnt0 | gnt1;
    assign bus.mem_we_o    = cmd_we;
    assign bus.mem_addr_o  = cmd_addr;
    assign bus.mem_be_o    = cmd_be;
    assign bus.mem_wdata_o = cmd_wdata;

    always_comb begin
        pipe_d[0] = '{valid: gnt0 | gnt1, owner: gnt1, we: cmd_we};
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            last_gnt_q <= last_gnt_d;
            pipe_q     <= pipe_d;
        end
    end

    assign head = pipe_q[MEM_LATENCY-1];
    assign rv0  = !rst && head.valid && !head.owner;
    assign rv1  = !rst && head.valid && head.owner;

    assign bus.p0_rvalid_o = rv0;
    assign bus.p1_rvalid_o = rv1;
    assign bus.p0_rdata_o  = (rv0 && !head.we) ? bus.mem_rdata_i : '0;
    assign bus.p1_rdata_o  = (rv1 && !head.we) ? bus.mem_rdata_i : '0;

    a_one_gnt: assert property (@(posedge clk) disable iff (rst)
        !(gnt0 && gnt1));
    a_one_rv: assert property (@(posedge clk) disable iff (rst)
        !(rv0 && rv1));
    a_rv0_src: assert property (@(posedge clk) disable iff (rst)
        rv0 |-> $past(gnt0, MEM_LATENCY));
    a_rv1_src: assert property (@(posedge clk) disable iff (rst)
        rv1 |-> $past(gnt1, MEM_LATENCY));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: latency-1 and latency-3 instances share stimulus;
// a queue-based reference model predicts grants, commands and responses.
module tb_dmem_arbiter;
    logic clk;
    logic rst;

    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .bus(b3)
    );

    assign b1.p0_req_i = req[0];   assign b3.p0_req_i = req[0];
    assign b1.p0_we_i = we[0];     assign b3.p0_we_i = we[0];
    assign b1.p0_addr_i = addr[0]; assign b3.p0_addr_i = addr[0];
    assign b1.p0_be_i = be[0];     assign b3.p0_be_i = be[0];
    assign b1.p0_wdata_i = wdata[0]; assign b3.p0_wdata_i = wdata[0];
    assign b1.p1_req_i = req[1];   assign b3.p1_req_i = req[1];
    assign b1.p1_we_i = we[1];     assign b3.p1_we_i = we[1];
    assign b1.p1_addr_i = addr[1]; assign b3.p1_addr_i = addr[1];
    assign b1.p1_be_i = be[1];     assign b3.p1_be_i = be[1];
    assign b1.p1_wdata_i = wdata[1]; assign b3.p1_wdata_i = wdata[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                          logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    // TCM environment for each instance: always ready, fixed read latency.
    bit [31:0] tcm [2][16];
    bit [31:0] rp1;
    bit [31:0] rp3 [3];

    always @(posedge clk) begin
        rp1 <= 32'h0;
        if (b1.mem_req_o) begin
            if (b1.mem_we_o)
                tcm[0][b1.mem_addr_o[5:2]] <= merge(tcm[0][b1.mem_addr_o[5:2]],
                                                    b1.mem_wdata_o, b1.mem_be_o);
            else
                rp1 <= tcm[0][b1.mem_addr_o[5:2]];
        end
        rp3[0] <= 32'h0;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
        if (b3.mem_req_o) begin
            if (b3.mem_we_o)
                tcm[1][b3.mem_addr_o[5:2]] <= merge(tcm[1][b3.mem_addr_o[5:2]],
                                                    b3.mem_wdata_o, b3.mem_be_o);
            else
                rp3[0] <= tcm[1][b3.mem_addr_o[5:2]];
        end
    end

    assign b1.mem_rdata_i = rp1;
    assign b3.mem_rdata_i = rp3[2];

    typedef struct {
        int        port;
        bit        we;
        bit [31:0] data;
        int        due;
    } exp_t;

    exp_t      q1 [$];
    exp_t      q3 [$];
    bit [31:0] refmem [16];
    int        last;
    int        cyc;
    bit        pend [2];
    int        errors;
    int        checks;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cmd_chk(string t, int g, logic g0, logic g1, logic mreq,
                           logic mwe, logic [31:0] ma, logic [3:0] mbe,
                           logic [31:0] mwd);
        chk({t, ".gnt0"}, g0, g == 0);
        chk({t, ".gnt1"}, g1, g == 1);
        chk({t, ".mem_req"}, mreq, g >= 0);
        if (g >= 0) begin
            chk({t, ".mem_we"}, mwe, we[g]);
            chk({t, ".mem_addr"}, ma, addr[g]);
            chk({t, ".mem_be"}, mbe, be[g]);
            chk({t, ".mem_wdata"}, mwd, wdata[g]);
        end else begin
            chk({t, ".idle_we"}, mwe, 0);
            chk({t, ".idle_be"}, mbe, 0);
            chk({t, ".idle_wdata"}, mwd, 0);
            if (rst) chk({t, ".rst_addr"}, ma, 0);
        end
    endtask

    task automatic rsp_chk(string t, bit hit, exp_t e, logic r0, logic r1,
                           logic [31:0] d0, logic [31:0] d1);
        logic [31:0] ed;
        ed = (hit && !e.we) ? e.data : 32'h0;
        chk({t, ".rvalid0"}, r0, hit && e.port == 0);
        chk({t, ".rvalid1"}, r1, hit && e.port == 1);
        chk({t, ".rdata0"}, d0, (hit && e.port == 0) ? ed : 32'h0);
        chk({t, ".rdata1"}, d1, (hit && e.port == 1) ? ed : 32'h0);
    endtask

    // One clock: check at negedge, advance model, return just after posedge.
    task automatic cycle();
        int   g;
        bit   h1, h3;
        exp_t e1, e3, n;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (req[0] && req[1]) g = (last == 1) ? 0 : 1;
            else if (req[0])      g = 0;
            else if (req[1])      g = 1;
        end
        cmd_chk("L1", g, b1.p0_gnt_o, b1.p1_gnt_o, b1.mem_req_o, b1.mem_we_o,
                b1.mem_addr_o, b1.mem_be_o, b1.mem_wdata_o);
        cmd_chk("L3", g, b3.p0_gnt_o, b3.p1_gnt_o, b3.mem_req_o, b3.mem_we_o,
                b3.mem_addr_o, b3.mem_be_o, b3.mem_wdata_o);
        e1 = '{port: 0, we: 0, data: 0, due: 0};
        e3 = e1;
        h1 = !rst && q1.size() != 0 && q1[0].due == cyc;
        h3 = !rst && q3.size() != 0 && q3[0].due == cyc;
        if (h1) e1 = q1.pop_front();
        if (h3) e3 = q3.pop_front();
        rsp_chk("L1", h1, e1, b1.p0_rvalid_o, b1.p1_rvalid_o,
                b1.p0_rdata_o, b1.p1_rdata_o);
        rsp_chk("L3", h3, e3, b3.p0_rvalid_o, b3.p1_rvalid_o,
                b3.p0_rdata_o, b3.p1_rdata_o);
        if (rst) begin
            q1.delete();
            q3.delete();
            last = 1;
            pend[0] = 0;
            pend[1] = 0;
        end else begin
            if (g >= 0) begin
                n = '{port: g, we: we[g], data: refmem[addr[g][5:2]], due: cyc + 1};
                q1.push_back(n);
                n.due = cyc + 3;
                q3.push_back(n);
                if (we[g])
                    refmem[addr[g][5:2]] = merge(refmem[addr[g][5:2]], wdata[g], be[g]);
                last = g;
            end
            pend[0] = req[0] && g != 0;
            pend[1] = req[1] && g != 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic ask(int p, logic w, logic [31:0] a, logic [3:0] b,
                       logic [31:0] d);
        req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
    endtask

    task automatic idle(int p);
        req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; be[p] = '0; wdata[p] = '0;
    endtask

    task automatic rnd(int p);
        ask(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
            4'($urandom_range(0, 15)), $urandom);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        last   = 1;
        pend[0] = 0;
        pend[1] = 0;
        idle(0);
        idle(1);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Port 1 seeds 0x10, then port 0 reads it back alone.
        ask(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        cycle();
        idle(1);
        ask(0, 1'b0, 32'h10, 4'hF, 32'h0);
        cycle();
        idle(0);
        repeat (4) cycle();

        // Both ports contend continuously: grants must alternate.
        for (int n = 0; n < 10; n++) begin
            for (int p = 0; p < 2; p++) if (!pend[p]) rnd(p);
            cycle();
        end
        idle(0);
        idle(1);
        repeat (4) cycle();

        // Partial write by port 1, then port 0 reads the merged word.
        ask(1, 1'b1, 32'h20, 4'b0011, 32'hA5A5A5A5);
        cycle();
        idle(1);
        ask(0, 1'b0, 32'h20, 4'hF, 32'h0);
        cycle();
        idle(0);
        repeat (4) cycle();

        // Four back-to-back port 0 reads.
        for (int n = 0; n < 4; n++) begin
            ask(0, 1'b0, 32'(n) << 2, 4'hF, 32'h0);
            cycle();
        end
        idle(0);
        repeat (5) cycle();

        // Reset one cycle after a port 1 read grant.
        ask(1, 1'b0, 32'h10, 4'hF, 32'h0);
        cycle();
        idle(1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        ask(0, 1'b0, 32'h14, 4'hF, 32'h0);
        ask(1, 1'b0, 32'h18, 4'hF, 32'h0);
        cycle();
        cycle();
        idle(0);
        idle(1);
        repeat (4) cycle();

        // Port 0 raises a write while port 1 wins, then withdraws it.
        ask(0, 1'b0, 32'h24, 4'hF, 32'h0);
        cycle();
        ask(0, 1'b1, 32'h30, 4'hF, 32'h11111111);
        ask(1, 1'b1, 32'h34, 4'hF, 32'h22222222);
        cycle();
        idle(0);
        for (int n = 0; n < 3; n++) begin
            ask(1, 1'b1, 32'h38, 4'hF, 32'h33333333 + 32'(n));
            cycle();
        end
        idle(1);
        repeat (4) cycle();

        // Randomised traffic with withdrawals and occasional resets.
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    if ($urandom_range(0, 9) == 0) idle(p);
                end else if ($urandom_range(0, 9) < 6) begin
                    rnd(p);
                end else begin
                    idle(p);
                end
            end
            rst = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(0);
        idle(1);
        repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
